// File: rtl/fir8_rx.sv
// fir8_rx: receive end of the 8-tap FIR PE chain.
// Tags genuine outputs, buffers them and streams bytes MSB first.
module fir8_rx #(
    parameter int LATENCY = 8,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     x_valid,
    input  logic [15:0]              Yin,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2
    } state_t;

    logic [LATENCY-1:0] vpipe;
    logic               y_valid;
    logic [15:0]        mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               full;
    logic               empty;
    logic               wr_en;
    logic               drop;
    logic               pop;
    logic [15:0]        rd_word;
    logic [15:0]        sh;
    logic [15:0]        sh_n;
    logic               txv_n;
    logic [7:0]         txd_n;
    state_t             state;
    state_t             state_n;

    assign y_valid = vpipe[LATENCY-1];
    assign full    = (fifo_level == FULL_LVL);
    assign empty   = (fifo_level == '0);
    assign wr_en   = y_valid && !full;
    assign drop    = y_valid && full;
    assign rd_word = mem[rd_ptr];

    // delay the sample valid to line up with the matching filter output
    always_ff @(posedge clk) begin
        if (reset) begin
            vpipe <= '0;
        end else begin
            vpipe[0] <= x_valid;
            for (int k = 1; k < LATENCY; k++) begin
                vpipe[k] <= vpipe[k-1];
            end
        end
    end

    // result storage; stale contents are harmless once pointers reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= Yin;
        end
    end

    // fifo pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !pop) begin
                fifo_level <= fifo_level + 1'b1;
            end else if (!wr_en && pop) begin
                fifo_level <= fifo_level - 1'b1;
            end
        end
    end

    // sticky overflow flag and saturating drop counter
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    // serializer state, holding word and registered byte outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            sh       <= '0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else begin
            state    <= state_n;
            sh       <= sh_n;
            tx_valid <= txv_n;
            tx_data  <= txd_n;
        end
    end

    // next state: pop straight into HI so the MSB follows the LSB gaplessly
    always_comb begin
        state_n = state;
        sh_n    = sh;
        txv_n   = tx_valid;
        txd_n   = tx_data;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                txv_n = 1'b0;
                if (!empty) begin
                    pop     = 1'b1;
                    sh_n    = rd_word;
                    state_n = HI;
                    txv_n   = 1'b1;
                    txd_n   = rd_word[15:8];
                end
            end
            HI: begin
                txv_n = 1'b1;
                if (tx_ready) begin
                    state_n = LO;
                    txd_n   = sh[7:0];
                end else begin
                    txd_n   = sh[15:8];
                end
            end
            LO: begin
                txv_n = 1'b1;
                if (tx_ready) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        sh_n    = rd_word;
                        state_n = HI;
                        txd_n   = rd_word[15:8];
                    end else begin
                        state_n = IDLE;
                        txv_n   = 1'b0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                txv_n   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fir8_rx.sv
// tb_fir8_rx: directed bench for fir8_rx.
// Expected byte stream is built from the stimulus; literal checks pin timing.
module tb_fir8_rx;

    localparam int L = 8;
    localparam int D = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic                x_valid;
    logic [15:0]         Yin;
    logic [7:0]          tx_data;
    logic                tx_valid;
    logic                tx_ready;
    logic [$clog2(D):0]  fifo_level;
    logic                overflow;
    logic [7:0]          drop_cnt;

    int total = 0;
    int bad   = 0;
    int ncyc;
    int first_v;
    int last_v;
    int nvalid;

    logic [7:0]  exq[$];
    logic        pv[L];
    logic [15:0] pd[L];
    logic        hold_prev = 1'b0;
    logic [7:0]  prev_data = 8'h00;
    logic [7:0]  eb;
    logic [15:0] w;

    fir8_rx #(.LATENCY(L), .DEPTH(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .x_valid    (x_valid),
        .Yin        (Yin),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic expect_word(input logic [15:0] v);
        exq.push_back(v[15:8]);
        exq.push_back(v[7:0]);
    endtask

    // one cycle: ideal filter delay line feeds Yin, junk when not valid
    task automatic cyc(input logic xv, input logic [15:0] v);
        x_valid = xv;
        Yin = pv[L-1] ? pd[L-1] : 16'hDEAD;
        for (int k = L - 1; k > 0; k--) begin
            pv[k] = pv[k-1];
            pd[k] = pd[k-1];
        end
        pv[0] = xv;
        pd[0] = v;
        @(posedge clk);
        #1;
        ncyc++;
        if (tx_valid) begin
            if (first_v < 0) first_v = ncyc;
            last_v = ncyc;
            nvalid++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 16'h0000);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        x_valid = 1'b0;
        Yin     = 16'h0000;
        exq.delete();
        for (int k = 0; k < L; k++) begin
            pv[k] = 1'b0;
            pd[k] = 16'h0000;
        end
        @(posedge clk);
        #1;
        reset   = 1'b0;
        ncyc    = 0;
        first_v = -1;
        last_v  = -1;
        nvalid  = 0;
    endtask

    // byte scoreboard and stall-stability check on every cycle
    always @(negedge clk) begin
        if (reset) begin
            hold_prev <= 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", {31'b0, tx_valid}, 32'd1);
                check("hold_data", {24'b0, tx_data}, {24'b0, prev_data});
            end
            if (tx_valid && tx_ready) begin
                if (exq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_byte: got %02h want none", tx_data);
                end else begin
                    eb = exq.pop_front();
                    check("byte", {24'b0, tx_data}, {24'b0, eb});
                end
            end
            hold_prev <= tx_valid && !tx_ready;
            prev_data <= tx_data;
        end
    end

    initial begin
        reset    = 1'b1;
        x_valid  = 1'b0;
        Yin      = 16'h0000;
        tx_ready = 1'b0;
        do_reset();
        check("rst_valid", {31'b0, tx_valid}, 32'd0);
        check("rst_data", {24'b0, tx_data}, 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_ovf", {31'b0, overflow}, 32'd0);
        check("rst_drop", {24'b0, drop_cnt}, 32'd0);

        // single result
        tx_ready = 1'b1;
        expect_word(16'h1234);
        cyc(1'b1, 16'h1234);
        idle(20);
        check("t1_first", first_v, L + 2);
        check("t1_count", nvalid, 2);
        check("t1_left", exq.size(), 0);

        // back-to-back results, no gaps
        do_reset();
        tx_ready = 1'b1;
        expect_word(16'h0004);
        expect_word(16'h000C);
        expect_word(16'h0019);
        cyc(1'b1, 16'h0004);
        cyc(1'b1, 16'h000C);
        cyc(1'b1, 16'h0019);
        idle(20);
        check("t2_first", first_v, L + 2);
        check("t2_count", nvalid, 6);
        check("t2_span", last_v - first_v, 5);
        check("t2_level", 32'(fifo_level), 32'd0);
        check("t2_left", exq.size(), 0);

        // full stall: capacity is fifo plus holding word
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            w = 16'h1000 + 16'(i) * 16'h0111;
            if (i < D + 1) expect_word(w);
            cyc(1'b1, w);
        end
        idle(L + 6);
        check("t3_level", 32'(fifo_level), 32'd4);
        check("t3_ovf", {31'b0, overflow}, 32'd1);
        check("t3_drop", {24'b0, drop_cnt}, 32'd1);
        check("t3_valid", {31'b0, tx_valid}, 32'd1);
        check("t3_msb", {24'b0, tx_data}, 32'h10);
        tx_ready = 1'b1;
        idle(20);
        check("t3_left", exq.size(), 0);
        check("t3_level0", 32'(fifo_level), 32'd0);

        // ready toggling every cycle
        do_reset();
        for (int i = 0; i < 60; i++) begin
            tx_ready = 1'(i % 2);
            if (i < 5 || i == 20) begin
                w = 16'hA0B1 + 16'(i) * 16'h0101;
                expect_word(w);
                cyc(1'b1, w);
            end else begin
                cyc(1'b0, 16'h0000);
            end
        end
        check("t4_left", exq.size(), 0);
        check("t4_ovf", {31'b0, overflow}, 32'd0);
        check("t4_drop", {24'b0, drop_cnt}, 32'd0);

        // reset in LO with three words queued
        do_reset();
        tx_ready = 1'b0;
        exq.push_back(8'h11);
        cyc(1'b1, 16'h1122);
        cyc(1'b1, 16'h3344);
        cyc(1'b1, 16'h5566);
        cyc(1'b1, 16'h7788);
        idle(L + 4);
        check("t5_pre_level", 32'(fifo_level), 32'd3);
        tx_ready = 1'b1;
        cyc(1'b0, 16'h0000);
        tx_ready = 1'b0;
        check("t5_lo_valid", {31'b0, tx_valid}, 32'd1);
        check("t5_lo_data", {24'b0, tx_data}, 32'h22);
        check("t5_lo_level", 32'(fifo_level), 32'd3);
        do_reset();
        check("t5_rst_valid", {31'b0, tx_valid}, 32'd0);
        check("t5_rst_level", 32'(fifo_level), 32'd0);
        check("t5_rst_ovf", {31'b0, overflow}, 32'd0);
        tx_ready = 1'b1;
        expect_word(16'hABCD);
        cyc(1'b1, 16'hABCD);
        idle(20);
        check("t5_first", first_v, L + 2);
        check("t5_count", nvalid, 2);
        check("t5_left", exq.size(), 0);

        // drop counter saturation
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 305; i++) begin
            w = 16'(i * 257 + 3);
            if (i < D + 1) expect_word(w);
            cyc(1'b1, w);
        end
        idle(L + 4);
        check("t6_drop", {24'b0, drop_cnt}, 32'd255);
        check("t6_ovf", {31'b0, overflow}, 32'd1);
        check("t6_level", 32'(fifo_level), 32'd4);
        tx_ready = 1'b1;
        idle(20);
        check("t6_left", exq.size(), 0);
        check("t6_ovf_sticky", {31'b0, overflow}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
